// File: rtl/audio_echo_engine.sv
// Multi-channel echo processor: each accepted frame is stored in a circular delay buffer
// and one bypass/echo/wet/mute frame is emitted. Build option: AUDIO_ECHO_FEEDBACK_EN.
module audio_echo_engine #(
  parameter int unsigned SAMPLE_W   = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned GAIN_SHIFT = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         in_available,
  output logic                         in_read,
  input  logic [NUM_CH*SAMPLE_W-1:0]   in_data,
  input  logic                         out_allowed,
  output logic                         out_write,
  output logic [NUM_CH*SAMPLE_W-1:0]   out_data,
  input  logic [DEPTH_LOG2-1:0]        delay_len,
  input  logic [1:0]                   mode,
  output logic                         busy
);

  localparam int unsigned FRAME_W = NUM_CH * SAMPLE_W;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] FILL_MAX = '1;
  localparam logic [SAMPLE_W-1:0]   SAT_MIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0]   SAT_MAX  = ~SAT_MIN;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_ECHO   = 2'b01;
  localparam logic [1:0] MODE_WET    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_EMIT
  } state_e;

  state_e                  state_q;
  logic [FRAME_W-1:0]      dry_q;
  logic [FRAME_W-1:0]      del_q;
  logic [FRAME_W-1:0]      store_q;
  logic [FRAME_W-1:0]      out_data_q;
  logic [1:0]              mode_q;
  logic [DEPTH_LOG2-1:0]   dly_q;
  logic [DEPTH_LOG2-1:0]   rd_addr_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DEPTH_LOG2-1:0]   fill_q;
  logic                    busy_q;

  logic [FRAME_W-1:0]      mem [DEPTH];

  logic [FRAME_W-1:0]      res_d;
  logic [FRAME_W-1:0]      store_d;
  logic signed [SAMPLE_W-1:0] dry_s;
  logic signed [SAMPLE_W-1:0] wet_s;
  logic [SAMPLE_W-1:0]     echo_s;
  logic                    accept;

  // Signed add clamped to the sample range.
  function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
      sat_add = s[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[SAMPLE_W-1:0];
    end
  endfunction

  assign accept    = (state_q == S_IDLE) & in_available & out_allowed & ~reset;
  assign in_read   = accept;
  assign out_write = (state_q == S_EMIT) & out_allowed & ~reset;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // Per-channel dry/wet/echo datapath, consumed in CALC.
  always_comb begin
    res_d   = '0;
    store_d = '0;
    dry_s   = '0;
    wet_s   = '0;
    echo_s  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dry_s = $signed(dry_q[c*SAMPLE_W +: SAMPLE_W]);
      if (dly_q == '0) begin
        wet_s = dry_s >>> GAIN_SHIFT;
      end else if (fill_q < dly_q) begin
        wet_s = '0;
      end else begin
        wet_s = $signed(del_q[c*SAMPLE_W +: SAMPLE_W]) >>> GAIN_SHIFT;
      end
      echo_s = sat_add(dry_s, wet_s);
      case (mode_q)
        MODE_BYPASS: res_d[c*SAMPLE_W +: SAMPLE_W] = dry_s;
        MODE_ECHO:   res_d[c*SAMPLE_W +: SAMPLE_W] = echo_s;
        MODE_WET:    res_d[c*SAMPLE_W +: SAMPLE_W] = wet_s;
        default:     res_d[c*SAMPLE_W +: SAMPLE_W] = '0;
      endcase
`ifdef AUDIO_ECHO_FEEDBACK_EN
      store_d[c*SAMPLE_W +: SAMPLE_W] = echo_s;
`else
      store_d[c*SAMPLE_W +: SAMPLE_W] = dry_s;
`endif
    end
  end

  // Frame sequencer: IDLE -> RD -> CALC -> WR -> EMIT.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dry_q      <= '0;
      store_q    <= '0;
      out_data_q <= '0;
      mode_q     <= '0;
      dly_q      <= '0;
      rd_addr_q  <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            dry_q     <= in_data;
            mode_q    <= mode;
            dly_q     <= delay_len;
            rd_addr_q <= wr_ptr_q - delay_len;
            busy_q    <= 1'b1;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          state_q <= S_CALC;
        end
        S_CALC: begin
          out_data_q <= res_d;
          store_q    <= store_d;
          state_q    <= S_WR;
        end
        S_WR: begin
          wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
          if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + DEPTH_LOG2'(1);
          end
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (out_allowed) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Delay buffer: synchronous read in RD, write in WR; contents survive reset.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_RD) begin
      del_q <= mem[rd_addr_q];
    end
    if ((state_q == S_WR) && !reset) begin
      mem[wr_ptr_q] <= store_q;
    end
  end

endmodule

// File: doc/audio_echo_engine.md
Name: audio_echo_engine

Overview:
- Parametrised, multi-channel sample processor placed between the audio controller's input FIFO interface and its output FIFO interface.
- Accepts one frame (all channels) per handshake.
- Stores each frame in a circular delay buffer and emits a bypass, echo, wet-only or muted frame through a write strobe gated by output space.
- Generalises the plain in->out passthrough in channel count, sample width, delay depth and processing mode.

Parameters:
SAMPLE_W, 32, signed two's-complement bits per channel sample
NUM_CH, 2, channels per frame; channel 0 occupies the LSBs
DEPTH_LOG2, 12, log2 of delay buffer depth in frames (4096 frames)
GAIN_SHIFT, 1, arithmetic right shift applied to the delayed (wet) sample

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
in_available  in  1  input frame present (audio_in_available)
in_read  out  1  frame consumed this cycle when high with in_available
in_data  in  NUM_CH*SAMPLE_W  input frame
out_allowed  in  1  output FIFO has space
out_write  out  1  one-cycle strobe; out_data valid
out_data  out  NUM_CH*SAMPLE_W  processed frame
delay_len  in  DEPTH_LOG2  delay in frames, 0..2^DEPTH_LOG2-1
mode  in  2  00 bypass, 01 echo, 10 wet-only, 11 mute
busy  out  1  high whenever FSM not in IDLE

Behaviour:
- One clock domain. Reset is synchronous, active-high, on CLOCK_50.
- Reset values: in_read=0, out_write=0, out_data=0, busy=0, wr_ptr=0, fill count=0, FSM=IDLE. Buffer RAM contents are not cleared.
- Handshake: in_read = (state==IDLE) & in_available & out_allowed (combinational). Frame accepted on that cycle. in_data, mode and delay_len are captured then; later changes do not affect the in-flight frame.
- FSM:
  - IDLE -> RD on accept. Latch frame; rd_addr = (wr_ptr - delay_len) mod 2^DEPTH_LOG2.
  - RD -> CALC: synchronous RAM read, 1 cycle.
  - CALC: compute per channel, register result.
    - dry = input sample.
    - wet = delayed sample >>> GAIN_SHIFT. wet = 0 if fill < delay_len. If delay_len==0, wet = dry >>> GAIN_SHIFT.
    - echo = dry + wet, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
    - Output per mode: bypass=dry; echo=echo; wet-only=wet; mute=0.
  - CALC -> WR: write store-word to RAM[wr_ptr]; wr_ptr increments and wraps 2^DEPTH_LOG2-1 -> 0; fill increments, saturating at 2^DEPTH_LOG2-1.
  - WR -> EMIT. In EMIT: if out_allowed, out_write=1 for exactly one cycle, out_data updated, -> IDLE. Otherwise hold EMIT with out_write=0 and out_data stable.
- Latency: out_write is high 4 cycles after the accept cycle when out_allowed stays high. Throughput: 1 frame per 5 cycles, well above 48 kHz at 50 MHz.
- The buffer stores every frame, including bypass and mute frames, so mode switches have history available.
- Reset mid-frame: frame discarded, no out_write, all state returns to reset values.
- Simultaneous in_available with the FSM outside IDLE: in_read stays 0 and the frame waits in the upstream FIFO.

Optional Feature:
AUDIO_ECHO_FEEDBACK_EN
- Defined: store-word = saturated (dry + wet) per channel, giving decaying repeated echoes.
- Undefined: store-word = dry, giving a single echo only.
- Output formula unchanged in both cases.

Test Plan:
- Reset, mode=00, frames L=0x00001000/R=0xFFFFF000, out_allowed=1 -> out_write 4 cycles after each in_read, out_data equals input, busy back to 0 after emit.
- DEPTH_LOG2=4, delay_len=3, mode=01, GAIN_SHIFT=1, impulse 0x40000000 then zeros:
  - without FEEDBACK_EN -> outputs 0x40000000,0,0,0x20000000,0,...
  - with FEEDBACK_EN -> adds 0x10000000 at frame 6 and 0x08000000 at frame 9.
- mode=01, delay_len=1, GAIN_SHIFT=0, two frames of 0x7FFFFFF0 -> second output saturates to 0x7FFFFFFF. Negative case: 0x80000010 twice -> 0x80000000.
- out_allowed forced low during EMIT for 10 cycles -> out_write stays 0, in_read stays 0, out_data stable; single out_write on the first cycle out_allowed returns high.
- DEPTH_LOG2=4, delay_len=15, 20 counting frames, mode=10 -> outputs 0 for frames 0-14; frame 15 outputs frame0>>>1. Checks pointer wrap and fill gating.
- Assert reset in RD/CALC/WR/EMIT states -> no out_write, next accepted frame with mode=10, delay_len=1 yields wet=0 (fill cleared).
